// File: rtl/serial_tx_buffered_pkg.sv
// Shared definitions for the buffered 8N1 serial transmitter.
// Holds the FSM state encoding and the frame constants.
package serial_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with power-of-2 depth and a separate occupancy counter.
// A push is refused while full, even if a pop happens in the same cycle.
module sync_byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide so they wrap at DEPTH on their own.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_tx_buffered.sv
// Buffered byte-to-serial transmitter: FIFO-fed 8N1 framer, line idles high.
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains straight into START if more bytes wait
module serial_tx_buffered
  import serial_tx_buffered_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1,
  localparam int BW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [7:0]    IN_DATA,
  input  logic          IN_VALID,
  output logic          OUT_READY,
  output logic          OUT_SERIAL_TX,
  output logic          OUT_BUSY,
  output logic [CW-1:0] OUT_COUNT
);

  tx_state_t     state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop;
  logic [7:0]    pop_data;
  logic          full;
  logic          empty;
  logic          baud_last;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (IN_VALID),
    .push_data (IN_DATA),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (OUT_COUNT)
  );

  assign baud_last     = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign OUT_READY     = !full;
  assign OUT_SERIAL_TX = tx_q;
  assign OUT_BUSY      = (state != IDLE) || (OUT_COUNT != '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= STOP_BIT;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_last ? '0 : baud_cnt + BW'(1);
    bit_d   = bit_idx;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = pop_data;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = pop_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // TX is registered from the level of the state being entered, so it never glitches.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      default: tx_d = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Directed bench for serial_tx_buffered: a CLKS_PER_BIT=4 and a =16 instance share stimulus via sel,
// a serial receiver model checks every frame against a queue of accepted bytes.
module tb_serial_tx_buffered;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       sel;
  logic       rx_en;

  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic [3:0] count_a, count_b;

  logic       ready_obs, tx_obs, busy_obs;
  logic [3:0] count_obs;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  serial_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid && !sel),
    .OUT_READY(ready_a), .OUT_SERIAL_TX(tx_a), .OUT_BUSY(busy_a), .OUT_COUNT(count_a)
  );

  serial_tx_buffered #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid && sel),
    .OUT_READY(ready_b), .OUT_SERIAL_TX(tx_b), .OUT_BUSY(busy_b), .OUT_COUNT(count_b)
  );

  assign ready_obs = sel ? ready_b : ready_a;
  assign tx_obs    = sel ? tx_b    : tx_a;
  assign busy_obs  = sel ? busy_b  : busy_a;
  assign count_obs = sel ? count_b : count_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] d);
    logic r;
    int   t;
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    forever begin
      r = ready_obs;
      @(posedge clk);
      if (r === 1'b1 || t >= 5000) break;
      @(negedge clk);
      t++;
    end
    check("push_accept_timeout", 32'(t < 5000), 1);
    if (r === 1'b1 && rx_en) expq.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy_obs !== 1'b0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle_timeout"}, 32'(t < 20000), 1);
    repeat (2) @(negedge clk);
    check({tag, "_queue_drained"}, 32'(expq.size()), 0);
  endtask

  // Receiver: detect start on a low sample, re-sample at bit centres.
  initial begin : rx_model
    logic [7:0] b;
    int         c;
    forever begin
      @(negedge clk);
      if (rx_en && tx_obs === 1'b0) begin
        c = sel ? 16 : 4;
        repeat (c / 2) @(negedge clk);
        check("rx_start_bit", 32'(tx_obs), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (c) @(negedge clk);
          b[i] = tx_obs;
        end
        repeat (c) @(negedge clk);
        check("rx_stop_bit", 32'(tx_obs), 1);
        check("rx_byte_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) check("rx_byte", 32'(b), 32'(expq.pop_front()));
      end
    end
  end

  initial begin : stim
    logic [9:0] frame;
    int         idx, frame_cycles, t, n;
    logic       full_seen, started, done, rdy;

    rst_n = 1'b0; sel = 1'b0; rx_en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_obs), 1);
    check("rst_ready", 32'(ready_obs), 1);
    check("rst_busy", 32'(busy_obs), 0);
    check("rst_count", 32'(count_obs), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset in the middle of a frame
    push_byte(8'h81);
    repeat (10) @(negedge clk);
    check("t1_pre_reset_tx", 32'(tx_obs), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_tx", 32'(tx_obs), 1);
    check("t1_ready", 32'(ready_obs), 1);
    check("t1_busy", 32'(busy_obs), 0);
    check("t1_count", 32'(count_obs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_obs !== 1'b1) n++;
    end
    check("t1_idle_low_samples", 32'(n), 0);
    check("t1_idle_busy", 32'(busy_obs), 0);

    // 2: single 0x55 frame, bit-exact waveform
    rx_en = 1'b1;
    push_byte(8'h55);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("t2_tx", 32'(tx_obs), 32'(frame[i / 4]));
    end
    check("t2_busy_in_stop", 32'(busy_obs), 1);
    @(negedge clk);
    check("t2_busy_after_stop", 32'(busy_obs), 0);
    check("t2_tx_idle", 32'(tx_obs), 1);
    wait_idle("t2");

    // 3: IN_VALID held with 0x00..0x0F
    idx = 0; full_seen = 1'b0; started = 1'b0; done = 1'b0; frame_cycles = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (tx_obs === 1'b0) started = 1'b1;
      if (started && busy_obs === 1'b0) begin
        done = 1'b1;
      end else begin
        if (started) frame_cycles++;
        check("t3_count_le_depth", 32'(count_obs <= 4'd8), 1);
        if (!full_seen && ready_obs === 1'b0) begin
          full_seen = 1'b1;
          check("t3_accepted_before_full", 32'(idx), 9);
        end
        rdy      = ready_obs;
        in_valid = (idx < 16);
        in_data  = 8'(idx);
        @(posedge clk);
        if (in_valid && rdy) begin
          expq.push_back(8'(idx));
          idx++;
        end
      end
    end
    in_valid = 1'b0;
    check("t3_done", 32'(done), 1);
    check("t3_full_seen", 32'(full_seen), 1);
    check("t3_bytes_accepted", 32'(idx), 16);
    check("t3_back_to_back_cycles", 32'(frame_cycles), 640);
    wait_idle("t3");

    // 4: held 0xAA while full is refused until a pop frees a slot
    for (int k = 0; k < 9; k++) push_byte(8'(8'h10 + k));
    check("t4_ready_full", 32'(ready_obs), 0);
    check("t4_count_full", 32'(count_obs), 8);
    in_data = 8'hAA; in_valid = 1'b1; t = 0;
    while (ready_obs !== 1'b1 && t < 200) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    check("t4_wait_timeout", 32'(t < 200), 1);
    check("t4_held_while_full", 32'(t > 0), 1);
    check("t4_count_after_pop", 32'(count_obs), 7);
    @(posedge clk);
    expq.push_back(8'hAA);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_count_after_push", 32'(count_obs), 8);
    wait_idle("t4");

    // 5: reset during data bit 3 of 0xC3, then a clean 0x3C
    rx_en = 1'b0;
    push_byte(8'hC3);
    repeat (18) @(negedge clk);
    check("t5_bit3_low", 32'(tx_obs), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tx_high", 32'(tx_obs), 1);
    check("t5_busy", 32'(busy_obs), 0);
    check("t5_count", 32'(count_obs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_en = 1'b1;
    push_byte(8'h3C);
    n = 0;
    while (busy_obs === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_busy_cycles", 32'(n), 41);
    wait_idle("t5");

    // 6: random loopback, CLKS_PER_BIT=4 then 16
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      for (int k = 0; k < 256; k++) begin
        n = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 2));
        repeat (n) @(negedge clk);
        push_byte(8'($urandom_range(0, 255)));
      end
      wait_idle(s == 0 ? "t6_cpb4" : "t6_cpb16");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
